uart_tx_buffered: RTL and testbench

Next-generation UART transmitter with a buffered, parametrised datapath. A synchronous FIFO accepts words through a valid/ready handshake, and a frame FSM serialises them. Data length (5..DATA_WIDTH), parity and 1/2 stop bits are selectable at run time. Baud rate comes from an internal programmable divider on the single system clock, so no separate TX clock domain is needed.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_buffered.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared types, constants and DATA_LEN clamp for the buffered  |
// |               UART transmitter.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_BREAK  = 3'd5
  } tx_state_t;

  localparam logic       PARITY_EVEN  = 1'b0;
  localparam logic       PARITY_ODD   = 1'b1;
  localparam logic [3:0] MIN_DATA_LEN = 4'd5;

  function automatic logic [3:0] clamp_data_len(input logic [3:0] len,
                                                input logic [3:0] max_len);
    if (len < MIN_DATA_LEN) return MIN_DATA_LEN;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_sync_fifo                                               |
// | Description : Show-ahead synchronous FIFO; pointers carry one wrap bit.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_pop,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  do_push;
  logic                  do_pop;

  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_buffered                                             |
// | Description : FIFO-buffered UART transmitter with run-time frame format    |
// |               and programmable baud divider. Optional line break support   |
// |               is enabled by defining UART_TX_BREAK_EN.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DIV_WIDTH-1:0]          BAUD_DIV,
  input  logic [3:0]                    DATA_LEN,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                          SEND_BREAK,
`endif
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  output logic                          TX_OUT,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

  tx_state_t             state_q, state_d;
  logic [DIV_WIDTH-1:0]  timer_q, timer_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  load;
  logic                  bit_end;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (DATA_VALID),
    .i_data  (P_DATA),
    .i_pop   (load),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (FIFO_COUNT)
  );

  assign DATA_READY = !fifo_full;
  assign TX_OUT     = tx_q;
  assign BUSY       = busy_q;
  assign bit_end    = (timer_q == div_q);

  // tx/busy are registered from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    state_d   = state_q;
    timer_d   = bit_end ? '0 : timer_q + 1'b1;
    div_d     = div_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    parity_d  = parity_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    load      = 1'b0;

    case (state_q)
      TX_IDLE: begin
        timer_d = '0;
        busy_d  = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (SEND_BREAK) begin
          state_d = TX_BREAK;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else
`endif
        if (!fifo_empty) load = 1'b1;
      end
      TX_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = TX_DATA;
          bit_cnt_d = '0;
        end
      end
      TX_DATA: begin
        tx_d = shreg_q[0];
        if (bit_end) begin
          shreg_d  = shreg_q >> 1;
          parity_d = parity_q ^ shreg_q[0];
          if (bit_cnt_q == len_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? TX_PARITY : TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      TX_PARITY: begin
        tx_d = parity_q;
        if (bit_end) begin
          state_d   = TX_STOP;
          bit_cnt_d = '0;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == 4'd0)) begin
            bit_cnt_d = 4'd1;
`ifdef UART_TX_BREAK_EN
          end else if (SEND_BREAK) begin
            state_d = TX_BREAK;
`endif
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      TX_BREAK: begin
        timer_d = '0;
        tx_d    = !SEND_BREAK;
        busy_d  = SEND_BREAK;
        if (!SEND_BREAK) state_d = TX_IDLE;
      end
`endif
      default: begin
        state_d = TX_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Frame configuration is frozen at pop time so mid-frame changes are ignored.
    if (load) begin
      state_d   = TX_START;
      timer_d   = '0;
      bit_cnt_d = '0;
      shreg_d   = fifo_head;
      div_d     = BAUD_DIV;
      len_d     = clamp_data_len(DATA_LEN, MAX_LEN);
      par_en_d  = PAR_EN;
      stop2_d   = STOP2;
      parity_d  = (PAR_TYP == PARITY_ODD);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= TX_IDLE;
      timer_q   <= '0;
      div_q     <= '0;
      len_q     <= MIN_DATA_LEN;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      parity_q  <= PARITY_EVEN;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_buffered                                          |
// | Description : Directed self-checking bench for uart_tx_buffered; the break |
// |               scenario is built only when UART_TX_BREAK_EN is defined.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_buffered;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] BAUD_DIV;
  logic [3:0]  DATA_LEN;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        STOP2;
`ifdef UART_TX_BREAK_EN
  logic        SEND_BREAK;
`endif
  logic [7:0]  P_DATA;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic        TX_OUT;
  logic        BUSY;
  logic [3:0]  FIFO_COUNT;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BAUD_DIV   (BAUD_DIV),
    .DATA_LEN   (DATA_LEN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
`ifdef UART_TX_BREAK_EN
    .SEND_BREAK (SEND_BREAK),
`endif
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .FIFO_COUNT (FIFO_COUNT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, expv);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Push one word into an idle transmitter and compare the line bit by bit.
  task automatic run_frame(input string tag, input logic [7:0] d, input int div,
                           input logic [3:0] len_cfg, input int nd, input logic pe,
                           input logic pt, input logic ep, input logic s2);
    logic [15:0] expv;
    logic [15:0] obs;
    logic        ob;
    int          nb;
    int          bc;
    BAUD_DIV = 16'(div);
    DATA_LEN = len_cfg;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    STOP2    = s2;
    expv = '0;
    obs  = '0;
    nb   = 0;
    expv[nb] = 1'b0; nb++;
    for (int i = 0; i < nd; i++) begin expv[nb] = d[i]; nb++; end
    if (pe) begin expv[nb] = ep; nb++; end
    expv[nb] = 1'b1; nb++;
    if (s2) begin expv[nb] = 1'b1; nb++; end
    P_DATA = d;
    DATA_VALID = 1'b1;
    tick;
    DATA_VALID = 1'b0;
    tick;
    check({tag, "_lat"}, {30'd0, BUSY, TX_OUT}, 32'd1);
    bc = 0;
    for (int b = 0; b < nb; b++) begin
      ob = expv[b];
      for (int c = 0; c <= div; c++) begin
        tick;
        if (BUSY) bc++;
        if (TX_OUT !== expv[b]) ob = TX_OUT;
      end
      obs[b] = ob;
    end
    check({tag, "_bits"}, {16'd0, obs}, {16'd0, expv});
    check({tag, "_busy_cycles"}, bc, nb * (div + 1));
    tick;
    check({tag, "_idle_after"}, {30'd0, BUSY, TX_OUT}, 32'd1);
  endtask

  logic       cap[$];
  logic       txl[150];
  logic       bsy[150];
  logic [9:0] fv;
  int         acc;
  int         acc_next;
  bit         seen_full;
  bit         started;
  bit         done;
  int         bad;

  initial begin
    RST = 1'b1;
    BAUD_DIV = 16'd3;
    DATA_LEN = 4'd8;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    STOP2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    SEND_BREAK = 1'b0;
`endif
    P_DATA = 8'h00;
    DATA_VALID = 1'b0;
    tick;
    tick;
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", BUSY, 0);
    check("rst_ready", DATA_READY, 1);
    check("rst_count", FIFO_COUNT, 0);
    RST = 1'b0;
    tick;

    // name, data, div, DATA_LEN, data bits, PAR_EN, PAR_TYP, parity bit, STOP2
    run_frame("a5_plain",  8'hA5, 3, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("a5_even",   8'hA5, 3, 4'd8,  8, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("a5_odd",    8'hA5, 3, 4'd8,  8, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame("ff_len7",   8'hFF, 0, 4'd7,  7, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame("80_len7p",  8'h80, 0, 4'd7,  7, 1'b1, 1'b0, 1'b0, 1'b1);
    run_frame("e0_len2",   8'hE0, 0, 4'd2,  5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("3c_len15",  8'h3C, 1, 4'd15, 8, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back: hold DATA_VALID until 10 words are accepted.
    BAUD_DIV = 16'd15;
    DATA_LEN = 4'd8;
    PAR_EN = 1'b0;
    STOP2 = 1'b0;
    acc = 0;
    seen_full = 0;
    started = 0;
    done = 0;
    for (int cyc = 0; cyc < 2200 && !done; cyc++) begin
      DATA_VALID = (acc < 10);
      P_DATA = 8'hC0 | 8'(acc);
      acc_next = (DATA_VALID && DATA_READY) ? acc + 1 : acc;
      tick;
      acc = acc_next;
      if (!seen_full && !DATA_READY) begin
        seen_full = 1;
        check("full_count", FIFO_COUNT, 8);
        check("full_accepted", acc, 9);
      end
      if (BUSY) begin
        started = 1;
        cap.push_back(TX_OUT);
      end else if (started) begin
        done = 1;
      end
    end
    DATA_VALID = 1'b0;
    check("b2b_done", done, 1);
    check("b2b_busy_len", cap.size(), 1600);
    for (int k = 0; k < 10; k++) begin
      fv = '0;
      for (int b = 0; b < 10; b++)
        if (k * 160 + b * 16 + 8 < cap.size()) fv[b] = cap[k * 160 + b * 16 + 8];
      check("b2b_frame", {22'd0, fv}, {22'd0, 1'b1, 8'hC0 | 8'(k), 1'b0});
    end
    tick;

    // Reset in the middle of the third data bit with three words queued.
    BAUD_DIV = 16'd3;
    for (int i = 0; i < 4; i++) begin
      DATA_VALID = 1'b1;
      P_DATA = 8'(17 * (i + 1));
      tick;
    end
    DATA_VALID = 1'b0;
    check("rst_pre_count", FIFO_COUNT, 3);
    for (int i = 0; i < 11; i++) tick;
    RST = 1'b1;
    tick;
    check("mid_rst_tx", TX_OUT, 1);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_count", FIFO_COUNT, 0);
    check("mid_rst_ready", DATA_READY, 1);
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (BUSY || !TX_OUT) bad++;
    end
    check("mid_rst_quiet", bad, 0);

`ifdef UART_TX_BREAK_EN
    // Word A starts at edge 2; break is seen at edges 28..47, past A's stop at edge 42.
    DATA_VALID = 1'b1;
    P_DATA = 8'h3C;
    tick;
    P_DATA = 8'h96;
    tick;
    DATA_VALID = 1'b0;
    for (int e = 3; e < 153; e++) begin
      SEND_BREAK = (e >= 28 && e <= 47);
      tick;
      txl[e - 3] = TX_OUT;
      bsy[e - 3] = BUSY;
    end
    fv = '0;
    for (int b = 0; b < 10; b++) fv[b] = txl[b * 4 + 2];
    check("brk_frame_a", {22'd0, fv}, {22'd0, 1'b1, 8'h3C, 1'b0});
    bad = 0;
    for (int k = 40; k <= 46; k++) if (!txl[k]) bad++;
    check("brk_low_cycles", bad, 5);
    check("brk_busy", {30'd0, bsy[42], txl[45]}, 32'd3);
    fv = '0;
    for (int b = 0; b < 10; b++) fv[b] = txl[47 + b * 4 + 2];
    check("brk_frame_b", {22'd0, fv}, {22'd0, 1'b1, 8'h96, 1'b0});
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
